// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus_arb round-robin read-bus arbiter.
//   arb_state_t : arbiter state encoding (IDLE, BUS, RESP)
//   idx_width() : width of an index into n items, never less than 1 bit
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_RESP
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Searches req upward from (ptr+1) mod N_REQ with wrap and reports the
// first set bit.
//   req       in  N_REQ  request vector
//   ptr       in  IW     index of the most recently served requester
//   win       out IW     winning index (0 when nothing is requested)
//   any_valid out 1      at least one request bit is set
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    win,
  output logic             any_valid
);

  always_comb begin
    int unsigned k;
    win       = '0;
    any_valid = 1'b0;
    k         = 0;
    // i runs 1..N_REQ so the last candidate checked is ptr itself.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!any_valid && req[k]) begin
        win       = IW'(k);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// bus_arb: round-robin arbiter sharing one read bus among N_REQ requesters.
// One transaction at a time: the winner's address is latched, the bus
// acknowledge is awaited, and the data is returned with a one-cycle pulse.
// Optional macro BUS_ARB_TIMEOUT_EN aborts a transaction after TIMEOUT
// BUS cycles without acknowledge (rsp_err_o=1, rsp_data_o=0).
//   clk_i        in  1              rising-edge clock
//   reset_i      in  1              asynchronous active-high reset
//   req_i        in  N_REQ          per-requester request level
//   req_ad_i     in  N_REQ*AD_LEN   flattened addresses, k at [k*AD_LEN +: AD_LEN]
//   gnt_o        out N_REQ          one-hot grant, high for whole transaction
//   rsp_valid_o  out N_REQ          one-hot one-cycle response pulse
//   rsp_data_o   out BUS_WIDTH      response data, held until next response
//   rsp_err_o    out 1              response was a timeout abort
//   bus_req_o    out 1              bus transaction active
//   bus_ad_o     out AD_LEN         bus address
//   bus_ack_i    in  1              bus has data this cycle
//   bus_data_i   in  BUS_WIDTH      bus read data
//   busy_o       out 1              arbiter not idle
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned AD_LEN    = 32,
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*AD_LEN-1:0] req_ad_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [BUS_WIDTH-1:0]    rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    bus_req_o,
  output logic [AD_LEN-1:0]       bus_ad_o,
  input  logic                    bus_ack_i,
  input  logic [BUS_WIDTH-1:0]    bus_data_i,
  output logic                    busy_o
);

  localparam int unsigned IW = idx_width(N_REQ);

  if (N_REQ < 1) begin : g_bad_n_req
    $error("bus_arb: N_REQ must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bus_arb: TIMEOUT must be at least 1");
  end

  arb_state_t        state, state_n;
  logic [IW-1:0]     ptr, idx, win;
  logic              any_req;
  logic [AD_LEN-1:0] win_ad;
  logic [N_REQ-1:0]  win_oh, idx_oh;
  logic              take_ack;
  logic              expire;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req       (req_i),
    .ptr       (ptr),
    .win       (win),
    .any_valid (any_req)
  );

  always_comb begin
    win_ad   = req_ad_i[32'(win)*AD_LEN +: AD_LEN];
    win_oh   = N_REQ'(1) << win;
    idx_oh   = N_REQ'(1) << idx;
    take_ack = (state == ARB_BUS) && bus_ack_i;
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = idx_width(TIMEOUT);

  logic [CW-1:0] cnt;
  logic          err_q;

  // Ack on the expiry cycle takes precedence over the abort.
  always_comb begin
    expire = (state == ARB_BUS) && !bus_ack_i && (cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != ARB_BUS) begin
        cnt <= '0;
      end else if (!bus_ack_i) begin
        cnt <= cnt + CW'(1);
      end
      if (take_ack) begin
        err_q <= 1'b0;
      end else if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_err_o = err_q;
`else
  always_comb begin
    expire = 1'b0;
  end

  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ARB_IDLE: if (any_req) state_n = ARB_BUS;
      ARB_BUS:  if (take_ack || expire) state_n = ARB_RESP;
      ARB_RESP: state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The address is latched straight into bus_ad_o, so later changes on
  // req_ad_i (or a dropped req_i) cannot disturb the transaction.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr         <= IW'(N_REQ - 1);
      idx         <= '0;
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      bus_req_o   <= 1'b0;
      bus_ad_o    <= '0;
      busy_o      <= 1'b0;
    end else begin
      busy_o      <= (state_n != ARB_IDLE);
      rsp_valid_o <= '0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            idx       <= win;
            bus_ad_o  <= win_ad;
            gnt_o     <= win_oh;
            bus_req_o <= 1'b1;
          end
        end
        ARB_BUS: begin
          if (take_ack || expire) begin
            rsp_valid_o <= idx_oh;
            rsp_data_o  <= take_ack ? bus_data_i : '0;
            gnt_o       <= '0;
            bus_req_o   <= 1'b0;
          end
        end
        ARB_RESP: begin
          ptr <= idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
module tb_bus_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] req_ad_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rsp_valid_o;
  logic [DW-1:0]   rsp_data_o;
  logic            rsp_err_o;
  logic            bus_req_o;
  logic [AW-1:0]   bus_ad_o;
  logic            bus_ack_i;
  logic [DW-1:0]   bus_data_i;
  logic            busy_o;

  logic [AW-1:0]   ad [N];

  int total   = 0;
  int bad     = 0;
  int rsp_cnt = 0;

  bus_arb #(
    .N_REQ     (N),
    .AD_LEN    (AW),
    .BUS_WIDTH (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .req_ad_i    (req_ad_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .bus_req_o   (bus_req_o),
    .bus_ad_o    (bus_ad_o),
    .bus_ack_i   (bus_ack_i),
    .bus_data_i  (bus_data_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) req_ad_i[k*AW +: AW] = ad[k];
  end

  // Continuous one-hot watch on grant and response, plus response counting.
  always @(negedge clk) begin
    if (!reset_i) begin
      total++;
      if ($countones(gnt_o) > 1 || $countones(rsp_valid_o) > 1) begin
        bad++;
        $display("FAIL onehot gnt=%b rsp_valid=%b (need at most one bit)", gnt_o, rsp_valid_o);
      end
      if (rsp_valid_o != '0) rsp_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_i    = 1'b1;
    req_i      = '0;
    bus_ack_i  = 1'b0;
    bus_data_i = '0;
    for (int k = 0; k < N; k++) ad[k] = '0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Waits (bounded) until a grant is visible at a falling edge.
  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_i    = 1'b1;
    req_i      = '0;
    bus_ack_i  = 1'b0;
    bus_data_i = '0;
    for (int k = 0; k < N; k++) ad[k] = '0;
    @(negedge clk);
    total++; if (gnt_o !== '0)       begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt_o); end
    total++; if (rsp_valid_o !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o); end
    total++; if (rsp_data_o !== '0)  begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err_o); end
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b want=0", bus_req_o); end
    total++; if (bus_ad_o !== '0)    begin bad++; $display("FAIL reset_bus_ad got=%h want=0", bus_ad_o); end
    total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    ad[0] = 32'h0000_1000;
    req_i = 4'b0001;
    @(negedge clk);
    total++; if (gnt_o !== 4'b0001)         begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt_o); end
    total++; if (bus_req_o !== 1'b1)        begin bad++; $display("FAIL single_bus_req got=%b want=1", bus_req_o); end
    total++; if (bus_ad_o !== 32'h0000_1000) begin bad++; $display("FAIL single_bus_ad got=%h want=00001000", bus_ad_o); end
    total++; if (busy_o !== 1'b1)           begin bad++; $display("FAIL single_busy got=%b want=1", busy_o); end
    @(negedge clk);
    bus_ack_i  = 1'b1;
    bus_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_ack_i = 1'b0;
    req_i     = '0;
    total++; if (rsp_valid_o !== 4'b0001)     begin bad++; $display("FAIL single_rsp_valid got=%b want=0001", rsp_valid_o); end
    total++; if (rsp_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rsp_data got=%h want=deadbeef", rsp_data_o); end
    total++; if (gnt_o !== '0)                begin bad++; $display("FAIL single_gnt_drop got=%b want=0", gnt_o); end
    total++; if (bus_req_o !== 1'b0)          begin bad++; $display("FAIL single_bus_req_drop got=%b want=0", bus_req_o); end
    @(negedge clk);
    total++; if (rsp_valid_o !== '0)          begin bad++; $display("FAIL single_pulse_len got=%b want=0", rsp_valid_o); end
    total++; if (busy_o !== 1'b0)             begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy_o); end
    total++; if (rsp_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data_hold got=%h want=deadbeef", rsp_data_o); end
  endtask

  task automatic test_round_robin();
    int         exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    bit         ok;
    do_reset();
    req_i     = 4'b1111;
    bus_ack_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rr_wait step=%0d no grant within budget", j); break; end
      want       = 4'(1) << exp_idx[j];
      bus_data_i = 32'h0000_00A0 + 32'(j);
      total++; if (gnt_o !== want) begin bad++; $display("FAIL rr_gnt step=%0d got=%b want=%b", j, gnt_o, want); end
      @(negedge clk);
      if (j == 4) req_i = '0;
      total++; if (rsp_valid_o !== want) begin bad++; $display("FAIL rr_rsp step=%0d got=%b want=%b", j, rsp_valid_o, want); end
      total++; if (rsp_data_o !== 32'h0000_00A0 + 32'(j)) begin bad++; $display("FAIL rr_data step=%0d got=%h want=%h", j, rsp_data_o, 32'h0000_00A0 + 32'(j)); end
    end
    req_i     = '0;
    bus_ack_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ptr_continue();
    // Pointer is at 0 after the previous task: serve 1,2,3, then only 2 and 3 request.
    int         exp_idx [5] = '{1, 2, 3, 2, 3};
    logic [3:0] want;
    bit         ok;
    req_i     = 4'b1111;
    bus_ack_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ptr_wait step=%0d no grant within budget", j); break; end
      want = 4'(1) << exp_idx[j];
      total++; if (gnt_o !== want) begin bad++; $display("FAIL ptr_gnt step=%0d got=%b want=%b", j, gnt_o, want); end
      @(negedge clk);
      if (j == 2) req_i = 4'b1100;
      if (j == 4) req_i = '0;
      total++; if (rsp_valid_o !== want) begin bad++; $display("FAIL ptr_rsp step=%0d got=%b want=%b", j, rsp_valid_o, want); end
    end
    req_i     = '0;
    bus_ack_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored();
    bit ok;
    int cnt0;
    do_reset();
    ad[0] = 32'h0000_2000;
    req_i = 4'b0001;
    wait_gnt(ok);
    total++; if (!ok) begin bad++; $display("FAIL ign_wait no grant within budget"); end
    req_i = '0;
    ad[0] = 32'h0000_3000;
    @(negedge clk);
    total++; if (bus_ad_o !== 32'h0000_2000) begin bad++; $display("FAIL ign_bus_ad got=%h want=00002000", bus_ad_o); end
    total++; if (gnt_o !== 4'b0001)          begin bad++; $display("FAIL ign_gnt_hold got=%b want=0001", gnt_o); end
    total++; if (bus_req_o !== 1'b1)         begin bad++; $display("FAIL ign_bus_req_hold got=%b want=1", bus_req_o); end
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h1234_5678;
    @(negedge clk);
    bus_ack_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b0001)     begin bad++; $display("FAIL ign_rsp got=%b want=0001", rsp_valid_o); end
    total++; if (rsp_data_o !== 32'h1234_5678) begin bad++; $display("FAIL ign_rsp_data got=%h want=12345678", rsp_data_o); end
    repeat (2) @(negedge clk);
    cnt0       = rsp_cnt;
    bus_ack_i  = 1'b1;
    bus_data_i = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    bus_ack_i = 1'b0;
    @(negedge clk);
    total++; if (rsp_cnt !== cnt0)            begin bad++; $display("FAIL spurious_ack_rsp got=%0d responses want=%0d", rsp_cnt, cnt0); end
    total++; if (busy_o !== 1'b0)             begin bad++; $display("FAIL spurious_ack_busy got=%b want=0", busy_o); end
    total++; if (rsp_data_o !== 32'h1234_5678) begin bad++; $display("FAIL spurious_ack_data got=%h want=12345678", rsp_data_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ad[0] = 32'h0000_4000;
    ad[1] = 32'h0000_4100;
    req_i = 4'b0001;
    wait_gnt(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_wait no grant within budget"); end
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_bus_req got=%b want=0", bus_req_o); end
    total++; if (gnt_o !== '0)       begin bad++; $display("FAIL rstmid_gnt got=%b want=0", gnt_o); end
    total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy_o); end
    req_i = 4'b0011;
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    total++; if (gnt_o !== 4'b0001)         begin bad++; $display("FAIL rstmid_first got=%b want=0001", gnt_o); end
    total++; if (bus_ad_o !== 32'h0000_4000) begin bad++; $display("FAIL rstmid_ad got=%h want=00004000", bus_ad_o); end
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0000_0042;
    req_i      = '0;
    @(negedge clk);
    bus_ack_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b0001) begin bad++; $display("FAIL rstmid_rsp got=%b want=0001", rsp_valid_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt0;
    do_reset();
    ad[0] = 32'h0000_5000;
    req_i = 4'b0001;
    wait_gnt(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_pre_wait no grant within budget"); end
    bus_ack_i  = 1'b1;
    bus_data_i = 32'hCAFE_F00D;
    @(negedge clk);
    bus_ack_i = 1'b0;
    req_i     = '0;
    total++; if (rsp_data_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL to_pre_data got=%h want=cafef00d", rsp_data_o); end
    @(negedge clk);
    ad[1] = 32'h0000_6000;
    req_i = 4'b0010;
    wait_gnt(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_wait no grant within budget"); end
    cnt0 = rsp_cnt;
`ifdef BUS_ARB_TIMEOUT_EN
    repeat (7) @(negedge clk);
    total++; if (bus_req_o !== 1'b1)  begin bad++; $display("FAIL to_before_expiry bus_req got=%b want=1", bus_req_o); end
    total++; if (rsp_valid_o !== '0)  begin bad++; $display("FAIL to_before_expiry rsp got=%b want=0", rsp_valid_o); end
    @(negedge clk);
    req_i = '0;
    total++; if (rsp_valid_o !== 4'b0010) begin bad++; $display("FAIL to_rsp got=%b want=0010", rsp_valid_o); end
    total++; if (rsp_err_o !== 1'b1)      begin bad++; $display("FAIL to_err got=%b want=1", rsp_err_o); end
    total++; if (rsp_data_o !== '0)       begin bad++; $display("FAIL to_data got=%h want=0", rsp_data_o); end
    total++; if (bus_req_o !== 1'b0)      begin bad++; $display("FAIL to_bus_req got=%b want=0", bus_req_o); end
    @(negedge clk);
    // Pointer advanced to 1, so 0 beats 1 here; ack lands on the expiry cycle.
    ad[0] = 32'h0000_7000;
    req_i = 4'b0011;
    wait_gnt(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_ack_wait no grant within budget"); end
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL to_ptr_adv got=%b want=0001", gnt_o); end
    req_i = '0;
    repeat (7) @(negedge clk);
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0000_0055;
    @(negedge clk);
    bus_ack_i = 1'b0;
    total++; if (rsp_valid_o !== 4'b0001)  begin bad++; $display("FAIL to_ackwin_rsp got=%b want=0001", rsp_valid_o); end
    total++; if (rsp_err_o !== 1'b0)       begin bad++; $display("FAIL to_ackwin_err got=%b want=0", rsp_err_o); end
    total++; if (rsp_data_o !== 32'h0000_0055) begin bad++; $display("FAIL to_ackwin_data got=%h want=00000055", rsp_data_o); end
`else
    repeat (20) @(negedge clk);
    total++; if (bus_req_o !== 1'b1)  begin bad++; $display("FAIL noto_bus_req got=%b want=1", bus_req_o); end
    total++; if (gnt_o !== 4'b0010)   begin bad++; $display("FAIL noto_gnt got=%b want=0010", gnt_o); end
    total++; if (rsp_cnt !== cnt0)    begin bad++; $display("FAIL noto_no_rsp got=%0d responses want=%0d", rsp_cnt, cnt0); end
    total++; if (rsp_err_o !== 1'b0)  begin bad++; $display("FAIL noto_err got=%b want=0", rsp_err_o); end
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0000_0077;
    @(negedge clk);
    bus_ack_i = 1'b0;
    req_i     = '0;
    total++; if (rsp_valid_o !== 4'b0010)      begin bad++; $display("FAIL noto_rsp got=%b want=0010", rsp_valid_o); end
    total++; if (rsp_data_o !== 32'h0000_0077) begin bad++; $display("FAIL noto_data got=%h want=00000077", rsp_data_o); end
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_continue();
    test_ignored();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
